// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states, frame geometry and line levels.
// The transmit block uses only the first four states.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_e;

  localparam int   DATA_BITS   = 8;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for the asynchronous serial line.
// Resets to the idle level so that reset does not look like a start edge.
module uart_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] ff_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ff_q <= '1;
    end else begin
      ff_q <= {ff_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = ff_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled bit timing, 3-sample mid-bit majority vote,
// valid/err strobes, and a pending/overrun handshake with the consumer.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  input  logic       ack,
  output logic [7:0] data,
  output logic       valid,
  output logic       err,
  output logic       overrun,
  output logic       busy
);

  localparam int            CW      = $clog2(OVERSAMPLE);
  localparam int            HALF    = OVERSAMPLE / 2;
  localparam logic [CW-1:0] CNT_MAX = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_S0  = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_S1  = CW'(HALF);
  localparam logic [CW-1:0] CNT_DEC = CW'(HALF + 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          s0_q, s1_q;
  logic          rxs, rxs_prev_q;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          pending_q, pending_d;
  logic          overrun_q, overrun_d;
  logic          decide, maj, fall, load_data;

  uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (in),
    .q_o   (rxs)
  );

  // Decision uses the two earlier samples plus the live sample at HALF+1.
  assign decide = (cnt_q == CNT_DEC);
  assign maj    = maj3(s0_q, s1_q, rxs);
  assign fall   = rxs_prev_q & ~rxs;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fall) state_d = START;
      START:   if (decide) state_d = (maj == START_LEVEL) ? DATA : IDLE;
      DATA:    if (decide && bit_idx_q == LAST_BIT) state_d = STOP;
      STOP:    if (decide) state_d = (maj == STOP_LEVEL) ? IDLE : BREAK;
      BREAK:   if (rxs == STOP_LEVEL) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    load_data = (state_q == STOP) && decide;
    valid_d   = load_data && (maj == STOP_LEVEL);
    err_d     = load_data && (maj != STOP_LEVEL);
  end

  // Counter only runs inside a frame; IDLE and BREAK hold it at zero so a
  // start edge always begins a fresh bit period.
  always_comb begin
    cnt_d     = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    if (state_q == IDLE || state_q == BREAK) begin
      cnt_d = '0;
    end
    if (state_q == START && decide) begin
      bit_idx_d = '0;
    end
    if (state_q == DATA && decide) begin
      bit_idx_d = bit_idx_q + 3'd1;
      shift_d   = {maj, shift_q[7:1]};
    end
    data_d    = load_data ? shift_q : data_q;
    pending_d = valid_q ? 1'b1 : (ack ? 1'b0 : pending_q);
    overrun_d = (valid_q && pending_q && !ack) ? 1'b1 : (ack ? 1'b0 : overrun_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      rxs_prev_q <= 1'b1;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      rxs_prev_q <= rxs;
      valid_q    <= valid_d;
      err_q      <= err_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      if (cnt_q == CNT_S0) s0_q <= rxs;
      if (cnt_q == CNT_S1) s1_q <= rxs;
    end
  end

  assign data    = data_q;
  assign valid   = valid_q;
  assign err     = err_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: vector table, directed corner sequences and random
// frames checked against a transaction-level receive model.
module tb_uart_rx;

  localparam int OS   = 16;
  localparam int SS   = 2;
  localparam int HALF = OS / 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       line_in;
  logic       ack;
  logic [7:0] data;
  logic       valid, err, overrun, busy;

  uart_rx #(.OVERSAMPLE(OS), .SYNC_STAGES(SS)) dut (
    .clk     (clk),
    .reset   (reset),
    .in      (line_in),
    .ack     (ack),
    .data    (data),
    .valid   (valid),
    .err     (err),
    .overrun (overrun),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nv = 0, ne = 0, nboth = 0, busy_cnt = 0, last_valid_cyc = 0;
  logic [7:0] vq[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      nv++;
      vq.push_back(data);
      last_valid_cyc = cyc;
    end
    if (err) ne++;
    if (valid && err) nboth++;
    if (busy) busy_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    line_in = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_len);
    drive(1'b0, OS);
    for (int i = 0; i < 8; i++) drive(b[i], OS);
    drive(stop_v, stop_len);
    line_in = 1'b1;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stop_v;
    logic       exp_valid;
    logic       exp_err;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int v0, e0, b0, s0, d;
    logic [7:0] rb;
    logic       rstop, rack, pend_m, ovr_m;
    int         gap;

    tbl[0] = '{8'hA5, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{8'h00, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{8'h3C, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{8'h80, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{8'h01, 1'b0, 1'b0, 1'b1};

    line_in = 1'b1;
    ack     = 1'b0;
    reset   = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("rst_data", data, 0);
    chk("rst_valid", valid, 0);
    chk("rst_err", err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    drive(1'b1, 4);

    // Vector table: one frame per entry, acked afterwards.
    for (int k = 0; k < 6; k++) begin
      v0 = nv; e0 = ne; s0 = cyc;
      send_frame(tbl[k].b, tbl[k].stop_v, OS);
      drive(1'b1, 6);
      chk($sformatf("tbl%0d_valid", k), nv - v0, tbl[k].exp_valid);
      chk($sformatf("tbl%0d_err", k), ne - e0, tbl[k].exp_err);
      chk($sformatf("tbl%0d_data", k), data, tbl[k].b);
      chk($sformatf("tbl%0d_busy", k), busy, 0);
      if (k == 0) begin
        d = last_valid_cyc - s0;
        chk("a5_latency", (d >= 155 && d <= 157) ? 156 : d, SS + 9 * OS + HALF + 2);
      end
      pulse_ack();
    end

    // One-cycle low glitch on an idle line is a false start.
    v0 = nv; e0 = ne; b0 = busy_cnt;
    drive(1'b0, 1);
    drive(1'b1, 30);
    chk("glitch_valid", nv - v0, 0);
    chk("glitch_err", ne - e0, 0);
    d = busy_cnt - b0;
    chk("glitch_busy_len", (d >= 9 && d <= 11) ? 10 : d, 10);

    // Bad stop bit with the line held low: err then BREAK until line high.
    v0 = nv; e0 = ne;
    drive(1'b0, OS);
    for (int i = 0; i < 8; i++) drive(logic'((8'h3C >> i) & 8'h01), OS);
    drive(1'b0, 40);
    chk("brk_err", ne - e0, 1);
    chk("brk_valid", nv - v0, 0);
    chk("brk_data", data, 8'h3C);
    chk("brk_busy_low_line", busy, 1);
    drive(1'b1, 6);
    chk("brk_busy_released", busy, 0);
    send_frame(8'h01, 1'b1, OS);
    drive(1'b1, 4);
    chk("brk_next_valid", nv - v0, 1);
    chk("brk_next_data", data, 8'h01);
    pulse_ack();
    drive(1'b1, 4);

    // Back-to-back frames without ack produce an overrun.
    v0 = nv;
    send_frame(8'h55, 1'b1, OS);
    send_frame(8'hAA, 1'b1, OS);
    drive(1'b1, 4);
    chk("b2b_count", nv - v0, 2);
    chk("b2b_first", vq[vq.size()-2], 8'h55);
    chk("b2b_second", vq[vq.size()-1], 8'hAA);
    chk("b2b_data", data, 8'hAA);
    chk("b2b_overrun", overrun, 1);
    pulse_ack();
    drive(1'b1, 2);
    chk("b2b_ack_clears", overrun, 0);
    send_frame(8'h5A, 1'b1, OS);
    drive(1'b1, 3);
    chk("b2b_pending_cleared", overrun, 0);

    // Mid-bit spike in bit 3 of 0x00 is outvoted.
    v0 = nv;
    drive(1'b1, 4);
    drive(1'b0, OS + 3 * OS + HALF);
    drive(1'b1, 1);
    drive(1'b0, OS - HALF - 1 + 4 * OS);
    drive(1'b1, OS);
    drive(1'b1, 3);
    chk("spike_valid", nv - v0, 1);
    chk("spike_data", data, 8'h00);
    chk("spike_overrun", overrun, 1);

    // Reset in the middle of frame 0xFF.
    v0 = nv; e0 = ne;
    drive(1'b0, OS);
    drive(1'b1, 4 * OS);
    chk("abort_busy_before", busy, 1);
    reset = 1'b1;
    drive(1'b1, 2);
    chk("abort_rst_data", data, 0);
    chk("abort_rst_valid", valid, 0);
    chk("abort_rst_err", err, 0);
    chk("abort_rst_overrun", overrun, 0);
    chk("abort_rst_busy", busy, 0);
    reset = 1'b0;
    drive(1'b1, 6 * OS);
    chk("abort_no_output", (nv - v0) + (ne - e0), 0);
    send_frame(8'h81, 1'b1, OS);
    drive(1'b1, 3);
    chk("abort_next_valid", nv - v0, 1);
    chk("abort_next_data", data, 8'h81);
    chk("abort_next_overrun", overrun, 0);
    pulse_ack();
    drive(1'b1, 4);

    // Random frames against a transaction-level model of pending/overrun.
    pend_m = 1'b0;
    ovr_m  = 1'b0;
    for (int k = 0; k < 24; k++) begin
      rb    = 8'($urandom_range(0, 255));
      rstop = ($urandom_range(0, 99) >= 15);
      rack  = $urandom_range(0, 1) == 1;
      gap   = $urandom_range(4, 20);
      v0 = nv; e0 = ne;
      send_frame(rb, rstop, OS);
      drive(1'b1, 2);
      if (rstop) begin
        if (pend_m) ovr_m = 1'b1;
        pend_m = 1'b1;
      end
      chk($sformatf("rnd%0d_valid", k), nv - v0, rstop ? 1 : 0);
      chk($sformatf("rnd%0d_err", k), ne - e0, rstop ? 0 : 1);
      chk($sformatf("rnd%0d_data", k), data, rb);
      chk($sformatf("rnd%0d_overrun", k), overrun, ovr_m);
      if (rack) begin
        pulse_ack();
        pend_m = 1'b0;
        ovr_m  = 1'b0;
      end
      drive(1'b1, gap);
    end

    chk("valid_err_exclusive", nboth, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive half of the team UART link: deserializes the 8N1 stream produced by the transmit block (idle-high line, one start bit at 0, 8 data bits LSB first, one stop bit at 1).
- Samples the asynchronous serial input with a synchronizer and a per-bit oversampling counter, takes a 3-sample majority vote at mid-bit, and presents each received byte with a one-cycle valid strobe.
- Flags framing errors and overruns.

Parameters:
- OVERSAMPLE, 16, clk cycles per serial bit; legal range 4..256.
- SYNC_STAGES, 2, flops in the input synchronizer; minimum 2.

Ports:
- clk  input  1  system clock; sole clock.
- reset  input  1  synchronous, active-high reset.
- in  input  1  asynchronous serial line; idle high.
- ack  input  1  consumer has taken the current byte; clears pending.
- data  output  8  last received byte; held until the next frame completes.
- valid  output  1  one-cycle pulse: good frame, data updated.
- err  output  1  one-cycle pulse: framing error (stop bit sampled 0).
- overrun  output  1  sticky: a byte completed while the previous byte was still pending; cleared by ack.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset is synchronous, active-high. It takes priority in any state, including mid-frame; the partial frame is discarded with no valid or err pulse.
- Reset values: state IDLE; data 0; valid 0; err 0; overrun 0; busy 0; pending 0; counters 0; all synchronizer flops 1.
- rxs is the output of the SYNC_STAGES synchronizer.
- HALF = OVERSAMPLE/2, integer division.
- cnt is a $clog2(OVERSAMPLE)-bit phase counter. It wraps from OVERSAMPLE-1 to 0.
- Bit decision: majority of rxs at cnt = HALF-1, HALF and HALF+1. The decision is taken on the edge at cnt = HALF+1.
- States:
  - IDLE: rxs 1->0 edge (previous rxs 1, current 0) -> START with cnt=0.
  - START: at decision, a majority of 1 is a false start -> IDLE with no output. A majority of 0 -> DATA with bitIdx=0. cnt keeps free-running.
  - DATA: at each decision, shift the majority into shift[7] and shift right (LSB first). bitIdx increments. At the 8th decision -> STOP.
  - STOP: at decision, data <= shift in every case.
    - Majority 1: valid pulses and the state goes to IDLE immediately. The early return allows back-to-back frames with no idle gap.
    - Majority 0: err pulses and the state goes to BREAK.
  - BREAK: wait until rxs = 1, then -> IDLE. No start detection happens in BREAK.
- valid and err are registered. They assert in the cycle after the STOP decision edge and never assert together.
- Latency: from the line falling edge to valid is SYNC_STAGES + 9*OVERSAMPLE + HALF + 2 cycles, ±1.
- pending:
  - Set on valid; cleared by ack.
  - If valid occurs while pending is 1 and ack is not asserted in that same cycle, overrun is set and data is still overwritten.
  - Simultaneous ack and valid: pending stays 1 and overrun is not set.
  - overrun is cleared by ack, or by reset.
- An err frame does not set pending.
- The counter wrapping at OVERSAMPLE-1 is the only bit-period timing. No fractional baud correction is applied.

Decomposition:
- Shared package uart_pkg:
  - state enum {IDLE, START, DATA, STOP, BREAK}. The transmit block uses the first four.
  - DATA_BITS = 8.
  - START_LEVEL = 0 and STOP_LEVEL = 1.
- One sub-module, uart_sync: a parameterized SYNC_STAGES-deep synchronizer with a reset value of 1.
- The FSM, counters and majority vote stay in uart_rx.

Test Plan:
- OVERSAMPLE=16, drive frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) at 16 cycles/bit -> exactly one valid pulse; data=0xA5; err=0; busy low after the pulse.
- 1-cycle low glitch on idle line -> START entered, majority 1 at decision, back to IDLE; no valid, no err; busy high for about 10 cycles only.
- Frame 0x3C with stop bit driven 0 and line held low 40 cycles, then idle -> one err pulse; data=0x3C; no valid; stays BREAK until the line is high; the next frame 0x01 is received correctly.
- Two back-to-back frames 0x55, 0xAA with no idle gap and no ack -> two valid pulses; data ends at 0xAA; overrun=1 after the second pulse; ack for 1 cycle clears overrun and pending.
- Single-cycle spike inverted at sample cnt=HALF of bit 3 in frame 0x00 -> majority rejects it; data=0x00, valid pulses.
- reset asserted at bit 4 of frame 0xFF, released, then frame 0x81 sent -> no output for the aborted frame; all outputs at reset values during reset; the next valid carries data=0x81.
